uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Full-duplex UART core with parametrised data width, bit period and FIFO depth. Each direction has its own synchronous FIFO: host writes are buffered and serialised on `Tx_o`, and frames received on `Rx_i` are buffered for the host to read. It replaces the fixed 8-bit UART datapath under `top` with a single-clock, error-reporting core.

## Interface
- `n`, 8: data bits per frame (5..9).
- `address`, 4: FIFO address width; depth `m = 2**address` per direction.
- `CLKS_PER_BIT`, 16: `clk_i` cycles per serial bit; even, at least 4.

Ports (clock and reset first):
- `clk_i` in 1: single system clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `Rx_i` in 1: serial input, asynchronous to `clk_i`.
- `Tx_o` out 1: serial output, idles high.
- `wr_i` in n: TX data.
- `ena_wr_i` in 1: push `wr_i` into the TX FIFO.
- `fl_full_o` out 1: TX FIFO full.
- `rd_o` out n: head of the RX FIFO (first-word fall-through).
- `ena_rd_i` in 1: pop the RX FIFO.
- `fl_empty_o` out 1: RX FIFO empty.
- `frame_err_o` out 1: sticky; a stop bit sampled low.
- `overrun_o` out 1: sticky; a received frame was dropped because the RX FIFO was full.
- `parity_err_o` out 1: sticky parity error.
- `clr_err_i` in 1: clears all sticky error flags.

## Operation
- Reset values: `Tx_o`=1, `fl_full_o`=0, `fl_empty_o`=1, `rd_o`=0, all error flags 0. Both FIFOs are emptied and both FSMs return to IDLE.
- Frame format: start bit (0), n data bits LSB first, optional parity bit, stop bit (1).

TX FSM (IDLE, START, DATA, PAR, STOP):
- Leaves IDLE when the TX FIFO is non-empty, popping the head into a shift register.
- Each state holds for exactly `CLKS_PER_BIT` cycles. DATA counts n bits.
- From STOP it goes back to IDLE, or, if the FIFO is non-empty, pops and enters START directly with no idle gap.

RX path:
- `Rx_i` passes through a 2-FF synchroniser, then a falling-edge detector.
- RX FSM (IDLE, START, DATA, PAR, STOP):
  - START waits `CLKS_PER_BIT/2` cycles and re-samples. If the line is high again it returns to IDLE (glitch) with no flags set.
  - DATA and PAR sample at mid-bit, every `CLKS_PER_BIT` cycles.
  - STOP samples at mid-bit. If the stop bit is 1, the frame is pushed (or dropped with `overrun_o`=1 if the FIFO is full). If it is 0, `frame_err_o`=1 and the frame is discarded.
  - The FSM then returns to IDLE and rearms on the next falling edge.

FIFO rules:
- Push when full is ignored.
- Pop when empty is ignored.
- Simultaneous push and pop: both take effect and the count is unchanged. When full, a push is accepted only if a pop occurs in the same cycle.
- Pointers are `address+1` bits wide; the MSB distinguishes full from empty on wrap-around.

Error flags:
- Flags set on the cycle after the event.
- `clr_err_i` has priority over a coincident new error.

Reset mid-frame: `Tx_o` returns high immediately (asynchronous) and any partial RX frame is discarded.

## Timing
- TX latency: a push on edge k makes `fl_empty` internal at k+1, and `Tx_o` falls at k+2.
- TX frame length: `(n+2)*CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` when parity is enabled.
- RX latency: synchroniser adds 2 cycles. A frame is written on the cycle after the stop-bit mid-sample, and `fl_empty_o` falls one cycle after that.
- `rd_o` is valid whenever `fl_empty_o`=0. It updates one cycle after a pop.
- `fl_full_o` rises the cycle after the m-th unpopped push.

## Configuration
- `UART_PARITY_EN` defined: an even-parity bit is inserted after the data bits on TX and checked on RX. A mismatch sets `parity_err_o` but the frame is still pushed.
- `UART_PARITY_EN` undefined: no PAR state in either FSM, and `parity_err_o` is tied to 0.

## Structure
- Package `uart_pkg` holds the `uart_state_t` enum (IDLE, START, DATA, PAR, STOP) and the bit-counter width function `$clog2(n+1)`.
- Sub-module `sync_fifo#(n,address)` is instantiated twice, once for TX and once for RX, with `wr_en`, `rd_en`, `full`, `empty` and `dout` ports.

## Test plan
Parameters: n=8, `CLKS_PER_BIT`=16, address=4, parity off unless stated.

1. Assert `rst_i` mid-frame -> `Tx_o`=1 immediately; `fl_empty_o`=1; all error flags 0.
2. Push 0xA5 -> `Tx_o` falls 2 cycles later. Start bit lasts 16 cycles, then bits 1,0,1,0,0,1,0,1, then stop; 160 cycles total.
3. Loop `Tx_o` back to `Rx_i` and push 0x00..0x0F -> `rd_o` pops 0x00..0x0F in order; no errors.
4. Drive `Rx_i` low for 4 cycles -> no push, no flags, RX FSM back in IDLE.
5. Send a frame with a 0 stop bit -> `frame_err_o`=1, `fl_empty_o` stays 1; `clr_err_i` clears the flag.
6. Receive 17 frames with no pops -> the 17th is dropped and `overrun_o`=1. With `UART_PARITY_EN` defined, a bad parity on 0x3C sets `parity_err_o` and 0x3C is still stored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART FIFO core.
//   uart_state_t  : state encoding used by both the TX and RX FSMs
//   bit_cnt_width : width of a counter that can hold a data-bit index 0..bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    function automatic int bit_cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en, din    : push request and data (ignored when full unless a pop
//                   happens in the same cycle)
//   rd_en         : pop request (ignored when empty)
//   dout          : head of the queue, forced to 0 while empty
//   full, empty   : status, derived combinationally from the pointers
module sync_fifo #(
    parameter int n       = 8,
    parameter int address = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [n-1:0] din,
    output logic [n-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** address;

    logic [n-1:0]   mem [DEPTH];
    logic [address:0] wr_ptr;
    logic [address:0] rd_ptr;
    logic           do_wr;
    logic           do_rd;

    // Extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[address] != rd_ptr[address]) &&
                   (wr_ptr[address-1:0] == rd_ptr[address-1:0]);

    assign do_rd = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    assign dout = empty ? '0 : mem[rd_ptr[address-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[address-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with a FIFO per direction, single clock domain.
// Optional feature macro: UART_PARITY_EN (even parity bit after the data
// bits on TX, checked on RX; when undefined parity_err_o is tied to 0).
// Ports:
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   Rx_i           : serial input (asynchronous, synchronised internally)
//   Tx_o           : serial output, idles high
//   wr_i, ena_wr_i : TX FIFO push data / strobe;  fl_full_o : TX FIFO full
//   rd_o, ena_rd_i : RX FIFO head / pop strobe;   fl_empty_o : RX FIFO empty
//   frame_err_o, overrun_o, parity_err_o : sticky errors, cleared by clr_err_i
//
// FSM states (shared by TX and RX):
//   state | meaning
//   IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
//   START | start bit; RX re-samples at mid-bit to reject glitches
//   DATA  | n data bits, LSB first
//   PAR   | even parity bit (only with UART_PARITY_EN)
//   STOP  | stop bit; RX decides push / frame error / overrun
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int n            = 8,
    parameter int address      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         Rx_i,
    output logic         Tx_o,
    input  logic [n-1:0] wr_i,
    input  logic         ena_wr_i,
    output logic         fl_full_o,
    output logic [n-1:0] rd_o,
    input  logic         ena_rd_i,
    output logic         fl_empty_o,
    output logic         frame_err_o,
    output logic         overrun_o,
    output logic         parity_err_o,
    input  logic         clr_err_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = bit_cnt_width(n);
    localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic         tx_full;
    logic         tx_empty;
    logic [n-1:0] tx_dout;
    logic         tx_pop;

    sync_fifo #(.n(n), .address(address)) u_tx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (ena_wr_i),
        .rd_en (tx_pop),
        .din   (wr_i),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign fl_full_o = tx_full;

    uart_state_t  tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [BW-1:0] tx_bit_cnt, tx_bit_cnt_nxt;
    logic [n-1:0]  tx_shift, tx_shift_nxt;
    logic          tx_line;
`ifdef UART_PARITY_EN
    logic          tx_par, tx_par_nxt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state   <= IDLE;
            tx_cnt     <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
`ifdef UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            tx_state   <= tx_state_nxt;
            tx_cnt     <= tx_cnt_nxt;
            tx_bit_cnt <= tx_bit_cnt_nxt;
            tx_shift   <= tx_shift_nxt;
`ifdef UART_PARITY_EN
            tx_par     <= tx_par_nxt;
`endif
        end
    end

    always_comb begin
        tx_state_nxt   = tx_state;
        tx_cnt_nxt     = tx_cnt;
        tx_bit_cnt_nxt = tx_bit_cnt;
        tx_shift_nxt   = tx_shift;
`ifdef UART_PARITY_EN
        tx_par_nxt     = tx_par;
`endif
        tx_pop         = 1'b0;
        tx_line        = 1'b1;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = tx_dout;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = ^tx_dout;
`endif
                    tx_cnt_nxt   = BIT_TC;
                    tx_state_nxt = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_cnt == '0) begin
                    tx_cnt_nxt     = BIT_TC;
                    tx_bit_cnt_nxt = LAST_BIT;
                    tx_state_nxt   = DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            DATA: begin
                tx_line = tx_shift[0];
                if (tx_cnt == '0) begin
                    tx_cnt_nxt   = BIT_TC;
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_bit_cnt == '0) begin
`ifdef UART_PARITY_EN
                        tx_state_nxt = PAR;
`else
                        tx_state_nxt = STOP;
`endif
                    end else begin
                        tx_bit_cnt_nxt = tx_bit_cnt - 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PAR: begin
                tx_line = tx_par;
                if (tx_cnt == '0) begin
                    tx_cnt_nxt   = BIT_TC;
                    tx_state_nxt = STOP;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                tx_line = 1'b1;
                if (tx_cnt == '0) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_shift_nxt = tx_dout;
`ifdef UART_PARITY_EN
                        tx_par_nxt   = ^tx_dout;
`endif
                        tx_cnt_nxt   = BIT_TC;
                        tx_state_nxt = START;
                    end else begin
                        tx_state_nxt = IDLE;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    // Registered line driver: glitch-free output, forced high by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) Tx_o <= 1'b1;
        else       Tx_o <= tx_line;
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev && !rx_s;

    uart_state_t   rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [BW-1:0] rx_bit_cnt, rx_bit_cnt_nxt;
    logic [n-1:0]  rx_shift, rx_shift_nxt;
    logic          rx_push_evt;
    logic          frame_evt;
    logic          rx_wr_en_q;
    logic          rx_full;
    logic          rx_empty;
    logic          ovr_evt;
`ifdef UART_PARITY_EN
    logic          par_evt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
            rx_wr_en_q <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit_cnt <= rx_bit_cnt_nxt;
            rx_shift   <= rx_shift_nxt;
            rx_wr_en_q <= rx_push_evt;
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt;
        rx_bit_cnt_nxt = rx_bit_cnt;
        rx_shift_nxt   = rx_shift;
        rx_push_evt    = 1'b0;
        frame_evt      = 1'b0;
`ifdef UART_PARITY_EN
        par_evt        = 1'b0;
`endif
        case (rx_state)
            IDLE: begin
                if (rx_fall) begin
                    rx_cnt_nxt   = HALF_TC;
                    rx_state_nxt = START;
                end
            end
            START: begin
                if (rx_cnt == '0) begin
                    if (!rx_s) begin
                        rx_cnt_nxt     = BIT_TC;
                        rx_bit_cnt_nxt = LAST_BIT;
                        rx_state_nxt   = DATA;
                    end else begin
                        rx_state_nxt = IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_s, rx_shift[n-1:1]};
                    rx_cnt_nxt   = BIT_TC;
                    if (rx_bit_cnt == '0) begin
`ifdef UART_PARITY_EN
                        rx_state_nxt = PAR;
`else
                        rx_state_nxt = STOP;
`endif
                    end else begin
                        rx_bit_cnt_nxt = rx_bit_cnt - 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PAR: begin
                if (rx_cnt == '0) begin
                    par_evt      = (rx_s != ^rx_shift);
                    rx_cnt_nxt   = BIT_TC;
                    rx_state_nxt = STOP;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                if (rx_cnt == '0) begin
                    if (rx_s) rx_push_evt = 1'b1;
                    else      frame_evt   = 1'b1;
                    rx_state_nxt = IDLE;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // rx_shift holds the completed frame until the next frame's data bits,
    // so it is still valid during the write cycle after the stop sample.
    sync_fifo #(.n(n), .address(address)) u_rx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .wr_en (rx_wr_en_q),
        .rd_en (ena_rd_i),
        .din   (rx_shift),
        .dout  (rd_o),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign fl_empty_o = rx_empty;
    assign ovr_evt    = rx_wr_en_q && rx_full && !(ena_rd_i && !rx_empty);

    // ------------------------------------------------------------------
    // Sticky error flags; clear wins over a coincident event
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (clr_err_i)      frame_err_o <= 1'b0;
            else if (frame_evt) frame_err_o <= 1'b1;
            if (clr_err_i)      overrun_o   <= 1'b0;
            else if (ovr_evt)   overrun_o   <= 1'b1;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          parity_err_o <= 1'b0;
        else if (clr_err_i) parity_err_o <= 1'b0;
        else if (par_evt)   parity_err_o <= 1'b1;
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
module tb_uart_fifo_core;

    localparam int N    = 8;
    localparam int ADDR = 4;
    localparam int CPB  = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         Rx_i;
    logic         Tx_o;
    logic [N-1:0] wr_i;
    logic         ena_wr_i;
    logic         fl_full_o;
    logic [N-1:0] rd_o;
    logic         ena_rd_i;
    logic         fl_empty_o;
    logic         frame_err_o;
    logic         overrun_o;
    logic         parity_err_o;
    logic         clr_err_i;

    logic loopback = 1'b0;
    logic rx_drv   = 1'b1;
`ifdef UART_PARITY_EN
    logic par_bad  = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0] frame_a5;

    always #5 clk = ~clk;

    assign Rx_i = loopback ? Tx_o : rx_drv;

    uart_fifo_core #(.n(N), .address(ADDR), .CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .Rx_i         (Rx_i),
        .Tx_o         (Tx_o),
        .wr_i         (wr_i),
        .ena_wr_i     (ena_wr_i),
        .fl_full_o    (fl_full_o),
        .rd_o         (rd_o),
        .ena_rd_i     (ena_rd_i),
        .fl_empty_o   (fl_empty_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o),
        .clr_err_i    (clr_err_i)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Drives one serial frame onto Rx_i from the bench side.
    task automatic send_frame(input logic [N-1:0] d, input logic stop_bit);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < N; i++) begin
            rx_drv = d[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ par_bad;
        tick(CPB);
`endif
        rx_drv = stop_bit;
        tick(CPB);
        rx_drv = 1'b1;
        tick(4);
    endtask

    task automatic pop_one();
        ena_rd_i = 1'b1;
        tick(1);
        ena_rd_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        wr_i      = '0;
        ena_wr_i  = 1'b0;
        ena_rd_i  = 1'b0;
        clr_err_i = 1'b0;
        tick(3);

        // Reset state
        check("rst_tx", Tx_o, 1);
        check("rst_full", fl_full_o, 0);
        check("rst_empty", fl_empty_o, 1);
        check("rst_rd", rd_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_perr", parity_err_o, 0);
        rst_i = 1'b0;
        tick(2);

        // TX of 0xA5: latency of two edges, then 10 bits of 16 cycles each
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        wr_i     = 8'hA5;
        ena_wr_i = 1'b1;
        tick(1);
        ena_wr_i = 1'b0;
        check("tx_lat_k", Tx_o, 1);
        tick(1);
        check("tx_lat_k1", Tx_o, 1);
        tick(1);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CPB; j++) begin
                if (j == 0 || j == CPB - 1)
                    check("tx_a5_bit", Tx_o, 16'(frame_a5[b]));
                tick(1);
            end
        end
        check("tx_after_frame", Tx_o, 1);
        tick(5);

        // Fill TX FIFO: 17 pushes, first is popped at once -> 16 stored
        for (int i = 0; i < 17; i++) begin
            wr_i     = 8'(i);
            ena_wr_i = 1'b1;
            tick(1);
            if (i == 15) check("full_at_15", fl_full_o, 0);
        end
        ena_wr_i = 1'b0;
        check("full_at_16", fl_full_o, 1);
        wr_i     = 8'hEE;
        ena_wr_i = 1'b1;
        tick(1);
        ena_wr_i = 1'b0;
        check("full_push_ignored", fl_full_o, 1);

        // Asynchronous reset mid-frame
        tick(40);
        check("tx_midframe_low", Tx_o, 0);
        #2 rst_i = 1'b1;
        #1;
        check("arst_tx", Tx_o, 1);
        check("arst_full", fl_full_o, 0);
        check("arst_empty", fl_empty_o, 1);
        @(negedge clk);
        rst_i = 1'b0;
        tick(20);
        check("post_rst_idle", Tx_o, 1);

        // Loopback 0x00..0x0F
        loopback = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            wr_i     = 8'(i);
            ena_wr_i = 1'b1;
            tick(1);
        end
        ena_wr_i = 1'b0;
        tick(2700);
        check("lb_not_empty", fl_empty_o, 0);
        for (int i = 0; i < 16; i++) begin
            check("lb_data", rd_o, 16'(i));
            pop_one();
        end
        check("lb_empty", fl_empty_o, 1);
        check("lb_ferr", frame_err_o, 0);
        check("lb_ovr", overrun_o, 0);
        loopback = 1'b0;
        tick(4);

        // 4-cycle glitch, then a valid frame proves the RX FSM rearmed
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        check("glitch_empty", fl_empty_o, 1);
        check("glitch_ferr", frame_err_o, 0);
        check("glitch_ovr", overrun_o, 0);
        send_frame(8'h5A, 1'b1);
        check("rx5a_not_empty", fl_empty_o, 0);
        check("rx5a_data", rd_o, 16'h5A);
        pop_one();
        check("rx5a_popped", fl_empty_o, 1);

        // Frame error: stop bit low
        send_frame(8'hC3, 1'b0);
        check("ferr_set", frame_err_o, 1);
        check("ferr_empty", fl_empty_o, 1);
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        check("ferr_clr", frame_err_o, 0);

        // Overrun: 17 frames without pops
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(8'h30 + i), 1'b1);
            if (i == 15) check("ovr_at_16", overrun_o, 0);
        end
        check("ovr_set", overrun_o, 1);
        for (int i = 0; i < 16; i++) begin
            check("ovr_data", rd_o, 16'(8'h30 + i));
            pop_one();
        end
        check("ovr_17th_dropped", fl_empty_o, 1);
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        check("ovr_clr", overrun_o, 0);

`ifdef UART_PARITY_EN
        par_bad = 1'b1;
        send_frame(8'h3C, 1'b1);
        par_bad = 1'b0;
        check("perr_set", parity_err_o, 1);
        check("perr_data", rd_o, 16'h3C);
        pop_one();
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        check("perr_clr", parity_err_o, 0);
`else
        check("perr_tied", parity_err_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
